// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback request and register-file write-port bundle for regfile_wb_arbiter
interface regfile_wb_arbiter_if #(
  parameter int addrsize = 5,
  parameter int regsnum  = 32
);
  logic [2:0]            src_valid;
  logic [2:0]            src_ready;
  logic [3*addrsize-1:0] src_addr;
  logic [95:0]           src_data;
  logic [addrsize-1:0]   wa0;
  logic [addrsize-1:0]   wa1;
  logic [31:0]           wd0;
  logic [31:0]           wd1;
  logic [1:0]            write;
  logic [regsnum-1:0]    pending;
  logic                  idle;

  modport master (
    input  src_valid, src_addr, src_data,
    output src_ready, wa0, wa1, wd0, wd1, write, pending, idle
  );

  modport slave (
    output src_valid, src_addr, src_data,
    input  src_ready, wa0, wa1, wd0, wd1, write, pending, idle
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - three-source writeback arbiter onto two register-file write ports; WB_BYPASS_EN enables empty-FIFO bypass
module regfile_wb_arbiter #(
  parameter int addrsize   = 5,
  parameter int regsnum    = 32,
  parameter int FIFO_DEPTH = 4
) (
  input logic                  clk,
  input logic                  rst,
  regfile_wb_arbiter_if.master bus
);
  localparam int NSRC = 3;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = $clog2(FIFO_DEPTH + 1);

  typedef logic [addrsize-1:0] addr_t;

  // Per-source FIFO storage and pointers
  addr_t       fifo_addr_q [NSRC][FIFO_DEPTH];
  addr_t       fifo_addr_d [NSRC][FIFO_DEPTH];
  logic [31:0] fifo_data_q [NSRC][FIFO_DEPTH];
  logic [31:0] fifo_data_d [NSRC][FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q [NSRC];
  logic [PW-1:0] wr_ptr_d [NSRC];
  logic [PW-1:0] rd_ptr_q [NSRC];
  logic [PW-1:0] rd_ptr_d [NSRC];
  logic [CW-1:0] count_q  [NSRC];
  logic [CW-1:0] count_d  [NSRC];

  // Round-robin start point and write-port registers
  logic [1:0]  rr_q, rr_d;
  addr_t       wa0_q, wa0_d, wa1_q, wa1_d;
  logic [31:0] wd0_q, wd0_d, wd1_q, wd1_d;
  logic [1:0]  write_q, write_d;

  // Arbitration view of each source
  logic [NSRC-1:0] src_ready;
  logic [NSRC-1:0] cand_valid;
  logic [NSRC-1:0] cand_bypass;
  addr_t           cand_addr [NSRC];
  logic [31:0]     cand_data [NSRC];
  logic            g0, g1;
  logic [1:0]      g0_src, g1_src;
  logic [NSRC-1:0] grant, push, pop;
  logic [regsnum-1:0] pending;

  function automatic logic [1:0] rr_next(input logic [1:0] s);
    return (s == 2'd2) ? 2'd0 : s + 2'd1;
  endfunction

  function automatic logic [1:0] scan_src(input logic [1:0] base, input logic [1:0] k);
    logic [2:0] sum;
    sum = {1'b0, base} + {1'b0, k};
    return (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
  endfunction

  // Ready depends only on the registered fill level, so a same-cycle pop never frees a slot early
  always_comb begin
    src_ready = '0;
    for (int i = 0; i < NSRC; i++) begin
      src_ready[i] = (count_q[i] != CW'(FIFO_DEPTH));
    end
  end

  // Candidate per source: the FIFO head, or the live request when bypassing an empty FIFO
  always_comb begin
    cand_bypass = '0;
    cand_valid  = '0;
    for (int i = 0; i < NSRC; i++) begin
`ifdef WB_BYPASS_EN
      cand_bypass[i] = (count_q[i] == '0) && bus.src_valid[i];
`else
      cand_bypass[i] = 1'b0;
`endif
      cand_valid[i] = (count_q[i] != '0) || cand_bypass[i];
      cand_addr[i]  = cand_bypass[i] ? bus.src_addr[i*addrsize +: addrsize]
                                     : fifo_addr_q[i][rd_ptr_q[i]];
      cand_data[i]  = cand_bypass[i] ? bus.src_data[i*32 +: 32]
                                     : fifo_data_q[i][rd_ptr_q[i]];
    end
  end

  // Scan from rr: first candidate takes port 0, next one with a different address takes port 1
  always_comb begin
    logic [1:0] s;
    s      = 2'd0;
    g0     = 1'b0;
    g1     = 1'b0;
    g0_src = 2'd0;
    g1_src = 2'd0;
    for (int k = 0; k < NSRC; k++) begin
      s = scan_src(rr_q, 2'(k));
      if (cand_valid[s]) begin
        if (!g0) begin
          g0     = 1'b1;
          g0_src = s;
        end else if (!g1 && (cand_addr[s] != cand_addr[g0_src])) begin
          g1     = 1'b1;
          g1_src = s;
        end
      end
    end
    grant = '0;
    if (g0) grant[g0_src] = 1'b1;
    if (g1) grant[g1_src] = 1'b1;
    if (g1) begin
      rr_d = rr_next(g1_src);
    end else if (g0) begin
      rr_d = rr_next(g0_src);
    end else begin
      rr_d = rr_q;
    end
  end

  // FIFO push/pop; a granted bypass request goes straight to the ports and is never stored
  always_comb begin
    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    pop  = '0;
    push = '0;
    for (int i = 0; i < NSRC; i++) begin
      pop[i]  = grant[i] && !cand_bypass[i];
      push[i] = bus.src_valid[i] && src_ready[i] && !(grant[i] && cand_bypass[i]);
      if (push[i]) begin
        fifo_addr_d[i][wr_ptr_q[i]] = bus.src_addr[i*addrsize +: addrsize];
        fifo_data_d[i][wr_ptr_q[i]] = bus.src_data[i*32 +: 32];
      end
      wr_ptr_d[i] = wr_ptr_q[i] + PW'(push[i]);
      rd_ptr_d[i] = rd_ptr_q[i] + PW'(pop[i]);
      count_d[i]  = count_q[i] + CW'(push[i]) - CW'(pop[i]);
    end
  end

  // Next write-port contents; an unused port keeps its last address and data
  always_comb begin
    write_d = {g1, g0};
    wa0_d   = g0 ? cand_addr[g0_src] : wa0_q;
    wd0_d   = g0 ? cand_data[g0_src] : wd0_q;
    wa1_d   = g1 ? cand_addr[g1_src] : wa1_q;
    wd1_d   = g1 ? cand_data[g1_src] : wd1_q;
  end

  // Pending mask covers only entries still queued, not those already in the port registers
  always_comb begin
    pending = '0;
    for (int i = 0; i < NSRC; i++) begin
      for (int j = 0; j < FIFO_DEPTH; j++) begin
        if (CW'(j) < count_q[i]) begin
          pending[fifo_addr_q[i][rd_ptr_q[i] + PW'(j)]] = 1'b1;
        end
      end
    end
  end

  // Control state and port registers; reset discards queued entries and any write in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NSRC; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
      rr_q    <= 2'd0;
      wa0_q   <= '0;
      wa1_q   <= '0;
      wd0_q   <= '0;
      wd1_q   <= '0;
      write_q <= 2'b00;
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        count_q[i]  <= count_d[i];
      end
      rr_q    <= rr_d;
      wa0_q   <= wa0_d;
      wa1_q   <= wa1_d;
      wd0_q   <= wd0_d;
      wd1_q   <= wd1_d;
      write_q <= write_d;
    end
  end

  // Payload storage is qualified by the pointers, so it carries no reset
  always_ff @(posedge clk) begin
    fifo_addr_q <= fifo_addr_d;
    fifo_data_q <= fifo_data_d;
  end

  assign bus.src_ready = src_ready;
  assign bus.wa0       = wa0_q;
  assign bus.wa1       = wa1_q;
  assign bus.wd0       = wd0_q;
  assign bus.wd1       = wd1_q;
  assign bus.write     = write_q;
  assign bus.pending   = pending;
  assign bus.idle      = (count_q[0] == '0) && (count_q[1] == '0) && (count_q[2] == '0)
                         && (write_q == 2'b00);
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
`timescale 1ns/1ps
module tb_regfile_wb_arbiter;
  localparam int AW    = 5;
  localparam int RN    = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mon_en = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.addrsize(AW), .regsnum(RN)) bus ();

  regfile_wb_arbiter #(.addrsize(AW), .regsnum(RN), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        rst_first;
    logic [2:0]  valid;
    logic [4:0]  a0, a1, a2;
    logic [31:0] d0, d1, d2;
    logic [1:0]  w1;
    logic [4:0]  wa0_1;
    logic [31:0] wd0_1;
    logic [4:0]  wa1_1;
    logic [31:0] wd1_1;
    logic [1:0]  w2;
    logic [4:0]  wa0_2;
    logic [31:0] wd0_2;
    logic [4:0]  wa1_2;
    logic [31:0] wd1_2;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] onehot(input logic [4:0] a);
    logic [31:0] m;
    m    = 32'h0;
    m[a] = 1'b1;
    return m;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk({tag, " rst write"}, bus.write, 2'b00);
    chk({tag, " rst ready"}, bus.src_ready, 3'b111);
    chk({tag, " rst pending"}, bus.pending, 32'h0);
    chk({tag, " rst idle"}, bus.idle, 1'b1);
    chk({tag, " rst wa0"}, bus.wa0, 5'd0);
  endtask

  // Port 0 is always used first, and a dual write never targets one register twice
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("port order", bus.write == 2'b10, 1'b0);
      if (bus.write == 2'b11) chk("dual same addr", bus.wa0 == bus.wa1, 1'b0);
    end
  end

  initial begin
    logic [31:0] got [$];
    logic        acc;
    int          k;

    bus.src_valid = 3'b000;
    bus.src_addr  = '0;
    bus.src_data  = '0;

    vecs[0] = '{1'b1, 3'b001, 5'd3, 5'd0, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0,
                2'b01, 5'd3, 32'hDEADBEEF, 5'd0, 32'h0, 2'b00, 5'd3, 32'hDEADBEEF, 5'd0, 32'h0};
    vecs[1] = '{1'b1, 3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33,
                2'b11, 5'd1, 32'h11, 5'd2, 32'h22, 2'b01, 5'd3, 32'h33, 5'd2, 32'h22};
    vecs[2] = '{1'b0, 3'b111, 5'd6, 5'd4, 5'd5, 32'h66, 32'h44, 32'h55,
                2'b11, 5'd6, 32'h66, 5'd4, 32'h44, 2'b01, 5'd5, 32'h55, 5'd4, 32'h44};
    vecs[3] = '{1'b1, 3'b011, 5'd7, 5'd7, 5'd0, 32'hA, 32'hB, 32'h0,
                2'b01, 5'd7, 32'hA, 5'd0, 32'h0, 2'b01, 5'd7, 32'hB, 5'd0, 32'h0};
    vecs[4] = '{1'b0, 3'b111, 5'd9, 5'd9, 5'd10, 32'h90, 32'h91, 32'hA0,
                2'b11, 5'd10, 32'hA0, 5'd9, 32'h90, 2'b01, 5'd9, 32'h91, 5'd9, 32'h90};
    vecs[5] = '{1'b1, 3'b101, 5'd0, 5'd0, 5'd31, 32'h1, 32'h0, 32'h2,
                2'b11, 5'd0, 32'h1, 5'd31, 32'h2, 2'b00, 5'd0, 32'h1, 5'd31, 32'h2};
    vecs[6] = '{1'b0, 3'b110, 5'd0, 5'd31, 5'd31, 32'h0, 32'h3, 32'h4,
                2'b01, 5'd31, 32'h3, 5'd31, 32'h2, 2'b01, 5'd31, 32'h4, 5'd31, 32'h2};

    do_reset("init");
    mon_en = 1'b1;

    // One batch per record, all accepted at a single edge, then two issue cycles and a drain check
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].rst_first) do_reset($sformatf("v%0d", i));
      chk($sformatf("v%0d ready", i), bus.src_ready, 3'b111);
      bus.src_valid = vecs[i].valid;
      bus.src_addr  = {vecs[i].a2, vecs[i].a1, vecs[i].a0};
      bus.src_data  = {vecs[i].d2, vecs[i].d1, vecs[i].d0};
      step();
      bus.src_valid = 3'b000;
`ifndef WB_BYPASS_EN
      chk($sformatf("v%0d queued write", i), bus.write, 2'b00);
      chk($sformatf("v%0d queued pending", i), bus.pending,
          (vecs[i].valid[0] ? onehot(vecs[i].a0) : 32'h0) |
          (vecs[i].valid[1] ? onehot(vecs[i].a1) : 32'h0) |
          (vecs[i].valid[2] ? onehot(vecs[i].a2) : 32'h0));
      step();
`endif
      chk($sformatf("v%0d c1 write", i), bus.write, vecs[i].w1);
      chk($sformatf("v%0d c1 wa0", i), bus.wa0, vecs[i].wa0_1);
      chk($sformatf("v%0d c1 wd0", i), bus.wd0, vecs[i].wd0_1);
      chk($sformatf("v%0d c1 wa1", i), bus.wa1, vecs[i].wa1_1);
      chk($sformatf("v%0d c1 wd1", i), bus.wd1, vecs[i].wd1_1);
      chk($sformatf("v%0d c1 pending", i), bus.pending,
          vecs[i].w2[0] ? onehot(vecs[i].wa0_2) : 32'h0);
      step();
      chk($sformatf("v%0d c2 write", i), bus.write, vecs[i].w2);
      chk($sformatf("v%0d c2 wa0", i), bus.wa0, vecs[i].wa0_2);
      chk($sformatf("v%0d c2 wd0", i), bus.wd0, vecs[i].wd0_2);
      chk($sformatf("v%0d c2 wa1", i), bus.wa1, vecs[i].wa1_2);
      chk($sformatf("v%0d c2 wd1", i), bus.wd1, vecs[i].wd1_2);
      chk($sformatf("v%0d c2 pending", i), bus.pending, 32'h0);
      step();
      chk($sformatf("v%0d c3 write", i), bus.write, 2'b00);
      chk($sformatf("v%0d c3 idle", i), bus.idle, 1'b1);
    end

    // Reset mid-operation: all three FIFOs loaded, then reset before anything issues from them
    do_reset("mid pre");
    bus.src_valid = 3'b111;
    bus.src_addr  = {5'd7, 5'd6, 5'd5};
    bus.src_data  = {32'h77, 32'h66, 32'h55};
    step();
    bus.src_valid = 3'b000;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid write", bus.write, 2'b00);
    chk("mid ready", bus.src_ready, 3'b111);
    chk("mid pending", bus.pending, 32'h0);
    chk("mid idle", bus.idle, 1'b1);
    chk("mid wa0", bus.wa0, 5'd0);
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("mid no r5 c%0d", c), bus.write, 2'b00);
    end

    // Backpressure: load once to leave rr at 2, then mul (r8) keeps port 0 and defers the ALU's r8 head
    do_reset("bp");
    bus.src_valid = 3'b010;
    bus.src_addr  = {5'd0, 5'd1, 5'd0};
    bus.src_data  = {32'h0, 32'h12345678, 32'h0};
    step();
    bus.src_valid = 3'b000;
    repeat (3) step();
    chk("bp primed idle", bus.idle, 1'b1);
    k = 0;
    bus.src_addr  = {5'd8, 5'd9, 5'd8};
    bus.src_data  = {32'hC0000000, 32'hB0000000, 32'hA0000000};
    bus.src_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      acc = bus.src_valid[0] & bus.src_ready[0];
      step();
      if (acc) begin
        k++;
        bus.src_data[31:0] = 32'hA0000000 + 32'(k);
      end
      chk($sformatf("bp ready e%0d", c), bus.src_ready[0], (c < 3) ? 1'b1 : 1'b0);
    end
    chk("bp accepts", k, 4);
    bus.src_valid = 3'b000;
    for (int c = 0; c < 12; c++) begin
      step();
`ifdef WB_BYPASS_EN
      if (c == 0) chk("bp ready after first pop", bus.src_ready[0], 1'b1);
`else
      if (c == 0) chk("bp ready before pop", bus.src_ready[0], 1'b0);
`endif
      if (c == 1) chk("bp ready after pop", bus.src_ready[0], 1'b1);
      if (bus.write[0] && bus.wd0[31:28] == 4'hA) got.push_back(bus.wd0);
      if (bus.write[1] && bus.wd1[31:28] == 4'hA) got.push_back(bus.wd1);
    end
    chk("bp alu writes", got.size(), 4);
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("bp alu order %0d", j), (j < got.size()) ? got[j] : 32'hFFFFFFFF,
          32'hA0000000 + 32'(j));
    end
    chk("bp final idle", bus.idle, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
